beat_sequencer: RTL and testbench



---
 rtl/beat_pkg.sv | 13 +
 rtl/rise_detect.sv | 18 +
 rtl/beat_sequencer.sv | 107 ++++++++++
 tb/tb_beat_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/beat_pkg.sv
// Shared types and constants for the beat sequencer.
package beat_pkg;

  localparam int CYC_CNT_W = 16;

  typedef enum logic [1:0] {
    BEAT_IDLE,
    BEAT_W1,
    BEAT_W2,
    BEAT_W3
  } beat_state_t;

endpackage

// File: rtl/rise_detect.sv
// One-flop rising-edge detector, used on the qd start button.
module rise_detect (
  input  logic t3_i,
  input  logic clr_i,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge t3_i or negedge clr_i) begin
    if (!clr_i) d_q <= 1'b0;
    else        d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/beat_sequencer.sv
// Machine-cycle beat generator (W1/W2/W3) with run/stop and single-step control.
// Define BEAT_CYCLE_COUNT_EN to build the completed-cycle counter on cyc_count_o.
//
// Handshake: there is no valid/ready pair; short_i is consumed only on the edge
// that ends W1, long_i only on the edge that ends W2, stop_i on any beat edge.
module beat_sequencer
  import beat_pkg::*;
(
  input  logic                 t3_i,
  input  logic                 clr_i,
  input  logic                 qd_i,
  input  logic                 step_mode_i,
  input  logic                 short_i,
  input  logic                 long_i,
  input  logic                 stop_i,
  output logic                 w1_o,
  output logic                 w2_o,
  output logic                 w3_o,
  output logic                 run_o,
  output logic                 cyc_last_o,
  output logic [CYC_CNT_W-1:0] cyc_count_o,
  output beat_state_t          dbg_state_o
);

  beat_state_t state_q, state_d;
  logic        run_q, run_d;
  logic        stop_pend_q, stop_pend_d;
  logic        qd_rise;
  logic        cyc_end;

  rise_detect u_qd_rise (
    .t3_i   (t3_i),
    .clr_i  (clr_i),
    .d_i    (qd_i),
    .rise_o (qd_rise)
  );

  always_ff @(posedge t3_i or negedge clr_i) begin
    if (!clr_i) begin
      state_q     <= BEAT_IDLE;
      run_q       <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    stop_pend_d = stop_pend_q;
    cyc_end     = 1'b0;
    case (state_q)
      BEAT_IDLE: begin
        if (qd_rise) begin
          state_d = BEAT_W1;
          run_d   = 1'b1;
        end
      end
      BEAT_W1: begin
        if (short_i) cyc_end = 1'b1;
        else         state_d = BEAT_W2;
      end
      BEAT_W2: begin
        if (long_i) state_d = BEAT_W3;
        else        cyc_end = 1'b1;
      end
      default: cyc_end = 1'b1;
    endcase
    if (state_q != BEAT_IDLE && stop_i) stop_pend_d = 1'b1;
    // A stop seen in the final beat itself still halts at this cycle's end.
    if (cyc_end) begin
      if (stop_pend_q || stop_i || step_mode_i) begin
        state_d     = BEAT_IDLE;
        run_d       = 1'b0;
        stop_pend_d = 1'b0;
      end else begin
        state_d = BEAT_W1;
      end
    end
  end

  assign w1_o        = (state_q == BEAT_W1);
  assign w2_o        = (state_q == BEAT_W2);
  assign w3_o        = (state_q == BEAT_W3);
  assign run_o       = run_q;
  assign cyc_last_o  = cyc_end;
  assign dbg_state_o = state_q;

`ifdef BEAT_CYCLE_COUNT_EN
  logic [CYC_CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;

  assign cyc_cnt_d = cyc_end ? cyc_cnt_q + 1'b1 : cyc_cnt_q;

  always_ff @(posedge t3_i or negedge clr_i) begin
    if (!clr_i) cyc_cnt_q <= '0;
    else        cyc_cnt_q <= cyc_cnt_d;
  end

  assign cyc_count_o = cyc_cnt_q;
`else
  assign cyc_count_o = '0;
`endif

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer: vector table, corner sequences, random run vs model.
module tb_beat_sequencer;
  import beat_pkg::*;

  logic t3 = 1'b0;
  logic clr_n = 1'b0;
  logic qd = 1'b0, step = 1'b0, sh = 1'b0, lg = 1'b0, st = 1'b0;
  logic w1, w2, w3, run, last;
  logic [CYC_CNT_W-1:0] cnt;
  beat_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  beat_sequencer dut (
    .t3_i        (t3),
    .clr_i       (clr_n),
    .qd_i        (qd),
    .step_mode_i (step),
    .short_i     (sh),
    .long_i      (lg),
    .stop_i      (st),
    .w1_o        (w1),
    .w2_o        (w2),
    .w3_o        (w3),
    .run_o       (run),
    .cyc_last_o  (last),
    .cyc_count_o (cnt),
    .dbg_state_o (dbg_state)
  );

  always #5 t3 = ~t3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs packed as {w1,w2,w3,run,cyc_last}.
  task automatic chk_outs(input string name, input logic [4:0] exp);
    chk(name, {27'b0, w1, w2, w3, run, last}, {27'b0, exp});
  endtask

  task automatic chk_cnt(input string name, input logic [15:0] exp_en);
`ifdef BEAT_CYCLE_COUNT_EN
    chk(name, {16'b0, cnt}, {16'b0, exp_en});
`else
    chk(name, {16'b0, cnt}, 32'h0);
`endif
  endtask

  // Inputs change just after the falling edge; outputs are checked 1ns later.
  task automatic drive(input logic q, input logic s, input logic shv, input logic lgv, input logic stv);
    @(negedge t3);
    qd = q; step = s; sh = shv; lg = lgv; st = stv;
    #1;
  endtask

  task automatic do_reset();
    @(negedge t3);
    clr_n = 1'b0;
    qd = 0; step = 0; sh = 0; lg = 0; st = 0;
    #1;
    chk_outs("reset_outs", 5'b00000);
    chk_cnt("reset_cnt", 16'h0);
    chk("reset_state", {30'b0, dbg_state}, {30'b0, BEAT_IDLE});
    @(negedge t3);
    clr_n = 1'b1;
  endtask

  typedef struct {
    logic       qd, step, sh, lg, st;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[16];

  // Reference model: beat number within the cycle (0 = stopped).
  int   m_beat, m_count;
  logic m_run, m_stop_pend, m_qd_prev;

  function automatic logic m_last();
    return (m_beat == 1 && sh) || (m_beat == 2 && !lg) || (m_beat == 3);
  endfunction

  task automatic model_edge();
    logic rise, fin;
    rise = qd && !m_qd_prev;
    m_qd_prev = qd;
    if (m_beat == 0) begin
      if (rise) begin m_beat = 1; m_run = 1; end
    end else begin
      fin = m_last();
      if (st) m_stop_pend = 1;
      if (fin) begin
        m_count = (m_count + 1) % 65536;
        if (m_stop_pend || step) begin
          m_beat = 0; m_run = 0; m_stop_pend = 0;
        end else m_beat = 1;
      end else m_beat = m_beat + 1;
    end
  endtask

  initial begin
    int tbl_cnt;
    logic [15:0] base;

    tbl[0]  = '{0,0,0,0,0, 5'b00000};
    tbl[1]  = '{1,0,0,0,0, 5'b00000};
    tbl[2]  = '{0,0,1,0,0, 5'b10011};
    tbl[3]  = '{0,0,0,1,0, 5'b10010};
    tbl[4]  = '{0,0,0,1,0, 5'b01010};
    tbl[5]  = '{0,0,0,0,0, 5'b00111};
    tbl[6]  = '{0,0,0,0,0, 5'b10010};
    tbl[7]  = '{0,0,0,0,1, 5'b01011};
    tbl[8]  = '{0,0,0,0,0, 5'b00000};
    tbl[9]  = '{1,1,0,0,0, 5'b00000};
    tbl[10] = '{0,1,1,1,0, 5'b10011};
    tbl[11] = '{1,0,0,0,0, 5'b00000};
    tbl[12] = '{0,0,0,0,1, 5'b10010};
    tbl[13] = '{0,0,0,1,0, 5'b01010};
    tbl[14] = '{0,0,0,0,0, 5'b00111};
    tbl[15] = '{0,0,0,0,0, 5'b00000};

    do_reset();
    tbl_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].qd, tbl[i].step, tbl[i].sh, tbl[i].lg, tbl[i].st);
      chk_outs($sformatf("tbl_%0d", i), tbl[i].exp);
      if (tbl[i].exp[0]) tbl_cnt++;
    end
    drive(0, 0, 0, 0, 0);
    chk_cnt("tbl_count", 16'(tbl_cnt));

    // Reset while W2 is showing: everything drops without waiting for an edge.
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk_outs("rst_w1", 5'b10010);
    drive(0, 0, 0, 0, 0);
    chk_outs("rst_w2", 5'b01011);
    #2 clr_n = 1'b0;
    #1;
    chk_outs("rst_async", 5'b00000);
    chk("rst_async_state", {30'b0, dbg_state}, {30'b0, BEAT_IDLE});
    chk_cnt("rst_async_cnt", 16'h0);
    @(negedge t3);
    clr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0);
      chk_outs("rst_stay_idle", 5'b00000);
    end

    // Single step, default length.
    base = cnt;
    drive(1, 1, 0, 0, 0);
    chk_outs("step_idle", 5'b00000);
    drive(0, 1, 0, 0, 0);
    chk_outs("step_w1", 5'b10010);
    drive(0, 1, 0, 0, 0);
    chk_outs("step_w2", 5'b01011);
    drive(0, 1, 0, 0, 0);
    chk_outs("step_done", 5'b00000);
    chk_cnt("step_cnt", base + 16'd1);

    // short+long together in W1, then a qd rise while running.
    base = cnt;
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0);
    chk_outs("conf_short_wins", 5'b10011);
    drive(0, 0, 0, 0, 0);
    chk_outs("conf_next_w1", 5'b10010);
    drive(1, 0, 0, 0, 1);
    chk_outs("conf_w2_stop", 5'b01011);
    drive(1, 0, 0, 0, 0);
    chk_outs("conf_no_restart", 5'b00000);
    drive(0, 0, 0, 0, 0);
    chk_outs("conf_still_idle", 5'b00000);
    chk_cnt("conf_cnt", base + 16'd2);

`ifdef BEAT_CYCLE_COUNT_EN
    force dut.cyc_cnt_q = 16'hFFFF;
    #1;
    release dut.cyc_cnt_q;
    chk_cnt("wrap_pre", 16'hFFFF);
    drive(1, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    chk_outs("wrap_w1", 5'b10011);
    drive(0, 0, 0, 0, 0);
    chk_cnt("wrap_post", 16'h0000);
`else
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 0);
      chk_cnt("macro_off_cnt", 16'h0);
    end
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    chk_outs("macro_off_stopped", 5'b00000);
`endif

    // Random run against the model.
    do_reset();
    m_beat = 0; m_count = 0; m_run = 0; m_stop_pend = 0; m_qd_prev = 0;
    for (int i = 0; i < 3000; i++) begin
      logic nqd, nstep;
      nqd   = ($urandom_range(0, 3) == 0) ? ~qd : qd;
      nstep = ($urandom_range(0, 15) == 0) ? ~step : step;
      drive(nqd, nstep, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 11) == 0);
      chk_outs("rand_outs", {m_beat == 1, m_beat == 2, m_beat == 3, m_run,
                             m_beat != 0 && m_last()});
      chk_cnt("rand_cnt", 16'(m_count));
      @(posedge t3);
      model_edge();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
